// File: rtl/alu_issue.sv
// Execute-stage issuer: latches one decoded request, drives the combinational
// ALU for one or two passes, and hands back a registered result over valid/ready.
module alu_issue #(
  parameter int WIDTH      = 16,
  parameter int SLBI_SHAMT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_func,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [7:0]       req_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic [3:0]       alu_oper,
  output logic             alu_inva,
  output logic             alu_invb,
  output logic             alu_sign,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zf,
  input  logic             alu_sf,
  input  logic             alu_of,
  input  logic             alu_cf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic [15:0]      ops_done
);

  typedef enum logic [1:0] {IDLE = 2'd0, P1 = 2'd1, P2 = 2'd2, DONE = 2'd3} state_t;

  localparam logic [3:0] FUNC_SLBI = 4'd13;
  localparam logic [3:0] OP_SLL    = 4'b0101;
  localparam logic [3:0] OP_OR     = 4'b0010;

  state_t           state_r, state_s;
  logic [3:0]       func_r;
  logic [7:0]       imm_r;
  logic [WIDTH-1:0] alu_a_r, alu_b_r, rsp_data_r;
  logic [3:0]       alu_oper_r, rsp_flags_r;
  logic             alu_cin_r, alu_inva_r, alu_invb_r, alu_sign_r;
  logic             rsp_valid_r, rsp_err_r;
  logic [15:0]      ops_cnt_r;
  logic             accept_s;

  // Control word {oper, inva, invb, cin, sign} for the first pass of each function.
  function automatic logic [7:0] decode(input logic [3:0] func);
    case (func)
      4'd0:    decode = {4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
      4'd1:    decode = {4'b0000, 1'b1, 1'b0, 1'b1, 1'b1};
      4'd2:    decode = {4'b0001, 1'b0, 1'b0, 1'b0, 1'b0};
      4'd3:    decode = {4'b0010, 1'b0, 1'b0, 1'b0, 1'b0};
      4'd4:    decode = {4'b0011, 1'b0, 1'b0, 1'b0, 1'b0};
      4'd5:    decode = {4'b0001, 1'b0, 1'b1, 1'b0, 1'b0};
      4'd6:    decode = {4'b0100, 1'b0, 1'b0, 1'b0, 1'b0};
      4'd7:    decode = {4'b0101, 1'b0, 1'b0, 1'b0, 1'b0};
      4'd8:    decode = {4'b0110, 1'b0, 1'b0, 1'b0, 1'b0};
      4'd9:    decode = {4'b0111, 1'b0, 1'b0, 1'b0, 1'b0};
      4'd10:   decode = {4'b1000, 1'b0, 1'b1, 1'b1, 1'b1};
      4'd11:   decode = {4'b1001, 1'b0, 1'b1, 1'b1, 1'b1};
      4'd12:   decode = {4'b1010, 1'b0, 1'b1, 1'b1, 1'b1};
      4'd13:   decode = {OP_SLL,  1'b0, 1'b0, 1'b0, 1'b0};
      default: decode = 8'h00;
    endcase
  endfunction

  function automatic logic is_legal(input logic [3:0] func);
    is_legal = (func <= FUNC_SLBI);
  endfunction

  assign accept_s  = req_valid && (state_r == IDLE);
  assign req_ready = (state_r == IDLE);

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = is_legal(req_func) ? P1 : DONE;
        end else begin
          state_s = IDLE;
        end
      end
      P1:      state_s = (func_r == FUNC_SLBI) ? P2 : DONE;
      P2:      state_s = DONE;
      DONE: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register, ALU drive registers, response and completion counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      func_r      <= 4'd0;
      imm_r       <= 8'd0;
      alu_a_r     <= '0;
      alu_b_r     <= '0;
      alu_oper_r  <= 4'd0;
      {alu_inva_r, alu_invb_r, alu_cin_r, alu_sign_r} <= 4'b0000;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
      rsp_flags_r <= 4'd0;
      rsp_err_r   <= 1'b0;
      ops_cnt_r   <= 16'd0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            func_r <= req_func;
            imm_r  <= req_imm;
            if (is_legal(req_func)) begin
              alu_a_r <= req_a;
              alu_b_r <= (req_func == FUNC_SLBI) ? WIDTH'(SLBI_SHAMT) : req_b;
              {alu_oper_r, alu_inva_r, alu_invb_r, alu_cin_r, alu_sign_r} <= decode(req_func);
            end else begin
              rsp_valid_r <= 1'b1;
              rsp_data_r  <= '0;
              rsp_flags_r <= 4'd0;
              rsp_err_r   <= 1'b1;
            end
          end
        end
        P1: begin
          if (func_r == FUNC_SLBI) begin
            // Second SLBI pass ORs the immediate into the shifted first result.
            alu_a_r    <= alu_out;
            alu_b_r    <= {{(WIDTH-8){1'b0}}, imm_r};
            alu_oper_r <= OP_OR;
            {alu_inva_r, alu_invb_r, alu_cin_r, alu_sign_r} <= 4'b0000;
          end else begin
            alu_a_r     <= '0;
            alu_b_r     <= '0;
            alu_oper_r  <= 4'd0;
            {alu_inva_r, alu_invb_r, alu_cin_r, alu_sign_r} <= 4'b0000;
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= alu_out;
            rsp_flags_r <= {alu_zf, alu_sf, alu_of, alu_cf};
            rsp_err_r   <= 1'b0;
          end
        end
        P2: begin
          alu_a_r     <= '0;
          alu_b_r     <= '0;
          alu_oper_r  <= 4'd0;
          {alu_inva_r, alu_invb_r, alu_cin_r, alu_sign_r} <= 4'b0000;
          rsp_valid_r <= 1'b1;
          rsp_data_r  <= alu_out;
          rsp_flags_r <= {alu_zf, alu_sf, alu_of, alu_cf};
          rsp_err_r   <= 1'b0;
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            ops_cnt_r   <= ops_cnt_r + 16'd1;
          end else begin
            rsp_valid_r <= 1'b1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign alu_a     = alu_a_r;
  assign alu_b     = alu_b_r;
  assign alu_cin   = alu_cin_r;
  assign alu_oper  = alu_oper_r;
  assign alu_inva  = alu_inva_r;
  assign alu_invb  = alu_invb_r;
  assign alu_sign  = alu_sign_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_flags = rsp_flags_r;
  assign rsp_err   = rsp_err_r;
  assign ops_done  = ops_cnt_r;

endmodule
